ex_mem_stage: RTL and testbench

Elastic EX/MEM boundary that captures each ALU result, its zero flag, store data, destination register and memory/writeback control bits, and presents them to the memory stage through a valid/ready handshake. It sits directly downstream of the ALU in the LEGv8 datapath. It absorbs up to DEPTH results while the memory stage stalls and resolves CBZ branch-taken from the captured zero flag. A flush input discards all in-flight entries on branch mispredict.

---
 rtl/ex_mem_stage_if.sv | 16 +
 rtl/ex_mem_stage.sv | 95 +++++++++
 tb/tb_ex_mem_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX/MEM handshake bundle: one valid/ready channel carrying the ALU result,
// zero flag, store data, destination register and memory/writeback control bits.
interface ex_mem_stage_if #(
  parameter int W = 64
);
  logic         valid;
  logic         ready;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] wdata;
  logic [4:0]   rd;
  logic [4:0]   ctrl;

  modport master (output valid, result, zero, wdata, rd, ctrl, input ready);
  modport slave  (input valid, result, zero, wdata, rd, ctrl, output ready);
endinterface

// File: rtl/ex_mem_stage.sv
// Elastic EX/MEM boundary: DEPTH-entry circular FIFO with flush and CBZ branch resolve.
// Optional EX operand-forwarding tap of the head entry enabled by EXMEM_FWD_EN.
module ex_mem_stage #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  ex_mem_stage_if.slave        i_up,
  ex_mem_stage_if.master       o_dn,
  output logic                 o_take_branch
`ifdef EXMEM_FWD_EN
  ,
  output logic                 o_fwd_valid,
  output logic [4:0]           o_fwd_rd,
  output logic [W-1:0]         o_fwd_data
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [W-1:0]  r_result [DEPTH];
  logic          r_zero   [DEPTH];
  logic [W-1:0]  r_wdata  [DEPTH];
  logic [4:0]    r_rd     [DEPTH];
  logic [4:0]    r_ctrl   [DEPTH];

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Ready depends only on registered occupancy, so a full buffer stays
  // closed for the cycle in which it pops.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = i_up.valid & ~w_full & ~i_flush;
  assign w_pop   = w_valid & o_dn.ready & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; stale slots are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_result[r_wr_ptr] <= i_up.result;
      r_zero[r_wr_ptr]   <= i_up.zero;
      r_wdata[r_wr_ptr]  <= i_up.wdata;
      r_rd[r_wr_ptr]     <= i_up.rd;
      r_ctrl[r_wr_ptr]   <= i_up.ctrl;
    end
  end

  assign i_up.ready    = ~w_full;
  assign o_dn.valid    = w_valid;
  assign o_dn.result   = w_valid ? r_result[r_rd_ptr] : '0;
  assign o_dn.zero     = w_valid ? r_zero[r_rd_ptr]   : 1'b0;
  assign o_dn.wdata    = w_valid ? r_wdata[r_rd_ptr]  : '0;
  assign o_dn.rd       = w_valid ? r_rd[r_rd_ptr]     : '0;
  assign o_dn.ctrl     = w_valid ? r_ctrl[r_rd_ptr]   : '0;
  assign o_take_branch = w_valid & r_ctrl[r_rd_ptr][4] & r_zero[r_rd_ptr];

`ifdef EXMEM_FWD_EN
  // X31 is the zero register in LEGv8, so it never forwards.
  logic w_fwd_valid;
  assign w_fwd_valid = w_valid & r_ctrl[r_rd_ptr][1] & (r_rd[r_rd_ptr] != 5'd31);
  assign o_fwd_valid = w_fwd_valid;
  assign o_fwd_rd    = w_fwd_valid ? r_rd[r_rd_ptr]     : '0;
  assign o_fwd_data  = w_fwd_valid ? r_result[r_rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized self-checking bench for ex_mem_stage against a queue-based model
// of the EX/MEM buffer; covers the forwarding tap when EXMEM_FWD_EN is defined.
module tb_ex_mem_stage;
  localparam int W     = 64;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] wdata;
    logic [4:0]   rd;
    logic [4:0]   ctrl;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic takeBranch;
`ifdef EXMEM_FWD_EN
  logic         fwdValid;
  logic [4:0]   fwdRd;
  logic [W-1:0] fwdData;
`endif

  ex_mem_stage_if #(.W(W)) upIf ();
  ex_mem_stage_if #(.W(W)) dnIf ();

  entry_t model[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (flush),
    .i_up          (upIf),
    .o_dn          (dnIf),
    .o_take_branch (takeBranch)
`ifdef EXMEM_FWD_EN
    ,
    .o_fwd_valid   (fwdValid),
    .o_fwd_rd      (fwdRd),
    .o_fwd_data    (fwdData)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic entry_t mkEntry(input logic [W-1:0] r, input logic z,
                                     input logic [4:0] c, input logic [4:0] d);
    entry_t e;
    e.result = r;
    e.zero   = z;
    e.wdata  = ~r;
    e.rd     = d;
    e.ctrl   = c;
    return e;
  endfunction

  function automatic entry_t randEntry();
    entry_t e;
    e.result = {$urandom, $urandom};
    e.zero   = ($urandom_range(0, 3) == 0);
    e.wdata  = {$urandom, $urandom};
    e.rd     = 5'($urandom_range(0, 31));
    e.ctrl   = 5'($urandom_range(0, 31));
    if (e.zero) e.result = '0;
    return e;
  endfunction

  // Compare every visible output against the head of the model queue.
  task automatic checkState(input string tag);
    entry_t h;
    logic hv;
    h  = '0;
    hv = (model.size() != 0);
    if (hv) h = model[0];
    checkOutput({tag, "_out_valid"}, dnIf.valid, hv);
    checkOutput({tag, "_in_ready"}, upIf.ready, (model.size() < DEPTH));
    checkOutput({tag, "_result"}, dnIf.result, h.result);
    checkOutput({tag, "_zero"}, dnIf.zero, h.zero);
    checkOutput({tag, "_wdata"}, dnIf.wdata, h.wdata);
    checkOutput({tag, "_rd"}, dnIf.rd, h.rd);
    checkOutput({tag, "_ctrl"}, dnIf.ctrl, h.ctrl);
    checkOutput({tag, "_take_branch"}, takeBranch, hv && h.ctrl[4] && h.zero);
`ifdef EXMEM_FWD_EN
    begin
      logic fv;
      fv = hv && h.ctrl[1] && (h.rd != 5'd31);
      checkOutput({tag, "_fwd_valid"}, fwdValid, fv);
      checkOutput({tag, "_fwd_rd"}, fwdRd, fv ? h.rd : 5'd0);
      checkOutput({tag, "_fwd_data"}, fwdData, fv ? h.result : '0);
    end
`endif
  endtask

  // Drive one cycle of inputs, check current outputs, clock, then advance the model.
  task automatic applyStimulus(input string tag, input logic v, input entry_t e,
                               input logic oready, input logic fl);
    logic doPush, doPop;
    upIf.valid  = v;
    upIf.result = e.result;
    upIf.zero   = e.zero;
    upIf.wdata  = e.wdata;
    upIf.rd     = e.rd;
    upIf.ctrl   = e.ctrl;
    dnIf.ready  = oready;
    flush       = fl;
    #1;
    checkState(tag);
    doPop  = (model.size() != 0) && oready && !fl;
    doPush = v && (model.size() < DEPTH) && !fl;
    @(posedge clk);
    #1;
    if (fl) model.delete();
    else begin
      if (doPop) void'(model.pop_front());
      if (doPush) model.push_back(e);
    end
  endtask

  initial begin
    entry_t e;
    upIf.valid  = 1'b1;
    upIf.result = 64'h10;
    upIf.zero   = 1'b0;
    upIf.wdata  = '0;
    upIf.rd     = 5'd1;
    upIf.ctrl   = 5'b00010;
    dnIf.ready  = 1'b0;
    flush       = 1'b0;

    #12;
    checkOutput("reset_out_valid", dnIf.valid, 1'b0);
    checkOutput("reset_in_ready", upIf.ready, 1'b1);
    checkOutput("reset_out_result", dnIf.result, 64'h0);
    checkState("reset");
    upIf.valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("first_push", 1'b1, mkEntry(64'h10, 1'b0, 5'b00010, 5'd1), 1'b0, 1'b0);
    checkOutput("first_out_valid", dnIf.valid, 1'b1);
    checkOutput("first_out_result", dnIf.result, 64'h10);
    applyStimulus("first_pop", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("fill1", 1'b1, mkEntry(64'd1, 1'b0, 5'b01010, 5'd2), 1'b0, 1'b0);
    applyStimulus("fill2", 1'b1, mkEntry(64'd2, 1'b0, 5'b01010, 5'd3), 1'b0, 1'b0);
    checkOutput("fill_in_ready", upIf.ready, 1'b0);
    e = mkEntry(64'd3, 1'b0, 5'b01010, 5'd4);
    applyStimulus("fill3_held", 1'b1, e, 1'b0, 1'b0);
    checkOutput("fill_head_1", dnIf.result, 64'd1);
    applyStimulus("drain1", 1'b1, e, 1'b1, 1'b0);
    checkOutput("fill_head_2", dnIf.result, 64'd2);
    applyStimulus("drain2", 1'b1, e, 1'b1, 1'b0);
    checkOutput("fill_head_3", dnIf.result, 64'd3);
    applyStimulus("drain3", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_empty", dnIf.valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus("stream", 1'b1, mkEntry(64'(100 + i), 1'b0, 5'b00010, 5'(i)), 1'b1, 1'b0);
      checkOutput("stream_in_ready", upIf.ready, 1'b1);
      checkOutput("stream_head", dnIf.result, 64'(100 + i));
    end
    applyStimulus("stream_end", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("cbz_taken", 1'b1, mkEntry(64'd0, 1'b1, 5'b10000, 5'd0), 1'b0, 1'b0);
    checkOutput("cbz_taken_flag", takeBranch, 1'b1);
    applyStimulus("cbz_pop", 1'b0, '0, 1'b1, 1'b0);
    applyStimulus("cbz_not", 1'b1, mkEntry(64'd0, 1'b0, 5'b10000, 5'd0), 1'b0, 1'b0);
    checkOutput("cbz_not_flag", takeBranch, 1'b0);
    applyStimulus("cbz_pop2", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("flush_fill1", 1'b1, randEntry(), 1'b0, 1'b0);
    applyStimulus("flush_fill2", 1'b1, randEntry(), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, randEntry(), 1'b1, 1'b1);
    checkOutput("flush_out_valid", dnIf.valid, 1'b0);
    checkOutput("flush_in_ready", upIf.ready, 1'b1);
    applyStimulus("post_flush", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("fwd_push", 1'b1, mkEntry(64'hABCD, 1'b0, 5'b00010, 5'd5), 1'b0, 1'b0);
`ifdef EXMEM_FWD_EN
    checkOutput("fwd_valid_rd5", fwdValid, 1'b1);
    checkOutput("fwd_rd_rd5", fwdRd, 5'd5);
    checkOutput("fwd_data_rd5", fwdData, 64'hABCD);
`endif
    applyStimulus("fwd_pop", 1'b0, '0, 1'b1, 1'b0);
    applyStimulus("fwd_push31", 1'b1, mkEntry(64'hABCD, 1'b0, 5'b00010, 5'd31), 1'b0, 1'b0);
`ifdef EXMEM_FWD_EN
    checkOutput("fwd_valid_rd31", fwdValid, 1'b0);
`endif
    applyStimulus("fwd_pop31", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", ($urandom_range(0, 9) < 7), randEntry(),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end

    applyStimulus("pre_reset1", 1'b1, randEntry(), 1'b0, 1'b0);
    applyStimulus("pre_reset2", 1'b1, randEntry(), 1'b0, 1'b0);
    #2;
    upIf.valid = 1'b1;
    rst_n = 1'b0;
    #1;
    model.delete();
    checkOutput("midreset_out_valid", dnIf.valid, 1'b0);
    checkOutput("midreset_out_result", dnIf.result, 64'h0);
    checkState("midreset");
    upIf.valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("after_reset", 1'b1, mkEntry(64'h55, 1'b1, 5'b10010, 5'd7), 1'b1, 1'b0);
    applyStimulus("final", 1'b0, '0, 1'b1, 1'b0);
    checkState("final_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
